// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared FSM state type and address field widths for the data cache.
package dcache_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 2;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - BYTE_W - $clog2(lines) - $clog2(words);
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage, one async read port and one write port.
module dcache_sram #(
  parameter int LINES = 16,
  parameter int TW    = 24,
  parameter int BW    = 128
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [$clog2(LINES)-1:0] i_rd_idx,
  output logic                     o_rd_valid,
  output logic                     o_rd_dirty,
  output logic [TW-1:0]            o_rd_tag,
  output logic [BW-1:0]            o_rd_data,
  input  logic                     i_we,
  input  logic [$clog2(LINES)-1:0] i_wr_idx,
  input  logic                     i_wr_dirty,
  input  logic [TW-1:0]            i_wr_tag,
  input  logic [BW-1:0]            i_wr_data
);
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TW-1:0]    r_tag  [LINES];
  logic [BW-1:0]    r_data [LINES];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end
  // Tag and data keep their contents across reset; only the flags are cleared.
  always_ff @(posedge i_clk) begin
    if (i_we && !i_rst) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller with zero-latency hits
// and a blocking WB/FILL miss sequence toward a block-wide memory port.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  cpu_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [32*WORDS-1:0]   mem_wdata_o,
  input  logic [32*WORDS-1:0]   mem_rdata_i,
  input  logic                  mem_ack_i
);
  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);
  localparam int BW = WORD_W * WORDS;
  state_t         r_state;
  state_t         w_next;
  logic [OW-1:0]  w_off;
  logic [IW-1:0]  w_idx;
  logic [TW-1:0]  w_tag;
  logic           w_rd_valid;
  logic           w_rd_dirty;
  logic [TW-1:0]  w_rd_tag;
  logic [BW-1:0]  w_rd_data;
  logic [BW-1:0]  w_store_blk;
  logic           w_hit;
  logic           w_fill_done;
  logic           w_unused;
  assign w_off    = cpu_addr_i[BYTE_W +: OW];
  assign w_idx    = cpu_addr_i[BYTE_W+OW +: IW];
  assign w_tag    = cpu_addr_i[ADDR_W-1 -: TW];
  assign w_unused = ^cpu_addr_i[BYTE_W-1:0];
  dcache_sram #(.LINES(LINES), .TW(TW), .BW(BW)) u_sram (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_dirty (w_rd_dirty),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_fill_done || (w_hit && cpu_we_i)),
    .i_wr_idx   (w_idx),
    .i_wr_dirty (!w_fill_done),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_fill_done ? mem_rdata_i : w_store_blk)
  );
  assign w_hit       = cpu_req_i && w_rd_valid && (w_rd_tag == w_tag) && (r_state == IDLE);
  assign w_fill_done = (r_state == FILL) && mem_ack_i;
  // A store hit rewrites the whole line with one word merged in, so a single write port suffices.
  always_comb begin
    w_store_blk = w_rd_data;
    w_store_blk[w_off*WORD_W +: WORD_W] = cpu_wdata_i;
  end
  assign cpu_rdata_o = (w_hit && !cpu_we_i) ? w_rd_data[w_off*WORD_W +: WORD_W] : '0;
  assign cpu_stall_o = cpu_req_i && !w_hit;
  assign mem_req_o   = r_state != IDLE;
  assign mem_we_o    = r_state == WB;
  assign mem_addr_o  = (r_state == WB)   ? {w_rd_tag, w_idx, {(OW+BYTE_W){1'b0}}} :
                       (r_state == FILL) ? {w_tag, w_idx, {(OW+BYTE_W){1'b0}}} : '0;
  assign mem_wdata_o = (r_state == WB) ? w_rd_data : '0;
  always_comb begin
    w_next = (r_state == IDLE) ? ((cpu_req_i && !w_hit) ? ((w_rd_valid && w_rd_dirty) ? WB : FILL) : IDLE) :
             (r_state == WB)   ? (mem_ack_i ? FILL : WB) :
                                 (mem_ack_i ? IDLE : FILL);
  end
  always_ff @(posedge clk_i) begin
    r_state <= rst_i ? IDLE : w_next;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scenario tasks with a scoreboard of expected memory transfers,
// a behavioural block memory, and inline checks of CPU-side results.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } xfer_t;

  xfer_t        exp_q[$];
  logic [127:0] mem_model [logic [31:0]];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'h3333_0000, a ^ 32'h2222_0000, a ^ 32'h1111_0000, a ^ 32'h0F0F_0000};
  endfunction

  function automatic logic [127:0] rd_blk(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : pat(a);
  endfunction

  function automatic logic [31:0] word(input logic [127:0] b, input int k);
    return b[k*32 +: 32];
  endfunction

  task automatic expect_xfer(input logic we, input logic [31:0] a, input logic [127:0] d);
    xfer_t x;
    x.we = we;
    x.addr = a;
    x.data = d;
    exp_q.push_back(x);
  endtask

  // Presents one CPU access, serves memory transfers with the given ack delay, and
  // checks each transfer against the scoreboard as the DUT issues it.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input int dly,
                        output logic [31:0] rd, output logic stalled);
    xfer_t x;
    logic [31:0] xa;
    logic xw;
    bit done;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd;
    #1;
    stalled = cpu_stall_o;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (!cpu_stall_o) done = 1'b1;
      else if (mem_req_o) begin
        xa = mem_addr_o;
        xw = mem_we_o;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL xfer_unexpected: got we=%0b addr=%h, required no transfer", xw, xa);
        end else begin
          x = exp_q.pop_front();
          if (xw !== x.we || xa !== x.addr || (x.we && mem_wdata_o !== x.data)) begin
            n_err++;
            $display("FAIL xfer: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                     xw, xa, mem_wdata_o, x.we, x.addr, x.data);
          end
        end
        if (xw) mem_model[xa] = mem_wdata_o;
        repeat (dly) begin
          @(negedge clk); #1;
          n_vec++;
          if (mem_req_o !== 1'b1 || mem_addr_o !== xa || mem_we_o !== xw) begin
            n_err++;
            $display("FAIL req_stable: got req=%0b we=%0b addr=%h, required req=1 we=%0b addr=%h",
                     mem_req_o, mem_we_o, mem_addr_o, xw, xa);
          end
        end
        mem_rdata_i = rd_blk(xa);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        #1;
      end else begin
        @(negedge clk); #1;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL access_timeout: addr=%h still stalled, required completion", a);
    end
    rd = cpu_rdata_o;
    @(negedge clk);
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_vec++;
    if ({cpu_stall_o, cpu_rdata_o} !== 33'd0) begin
      n_err++; $display("FAIL reset_cpu: got stall=%0b rdata=%h, required 0/0", cpu_stall_o, cpu_rdata_o);
    end
    n_vec++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 162'd0) begin
      n_err++; $display("FAIL reset_mem: got req=%0b we=%0b addr=%h wdata=%h, required all 0",
                        mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
  endtask

  task automatic test_cold_load;
    logic [127:0] b;
    logic [31:0] rd;
    logic st;
    b = pat(32'h100);
    b[63:32] = 32'hDEAD_BEEF;
    mem_model[32'h100] = b;
    expect_xfer(1'b0, 32'h100, '0);
    access(1'b0, 32'h104, 32'h0, 1, rd, st);
    n_vec++;
    if (st !== 1'b1) begin n_err++; $display("FAIL cold_stall: got %0b, required 1", st); end
    n_vec++;
    if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cold_rdata: got %h, required deadbeef", rd); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL cold_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_store_hit;
    logic [31:0] rd;
    logic st;
    access(1'b1, 32'h104, 32'h1234_5678, 0, rd, st);
    n_vec++;
    if (st !== 1'b0) begin n_err++; $display("FAIL store_hit_stall: got %0b, required 0", st); end
    access(1'b0, 32'h104, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== 32'h1234_5678 || st !== 1'b0) begin
      n_err++; $display("FAIL store_readback: got %h stall=%0b, required 12345678 stall=0", rd, st);
    end
    access(1'b0, 32'h108, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h100), 2) || st !== 1'b0) begin
      n_err++; $display("FAIL hit_word2: got %h stall=%0b, required %h stall=0", rd, st, word(pat(32'h100), 2));
    end
    #1;
    n_vec++;
    if (cpu_rdata_o !== 32'h0 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL idle_outputs: got rdata=%h stall=%0b, required 0/0", cpu_rdata_o, cpu_stall_o);
    end
  endtask

  task automatic test_dirty_evict;
    logic [127:0] v;
    logic [31:0] rd;
    logic st;
    v = mem_model[32'h100];
    v[63:32] = 32'h1234_5678;
    expect_xfer(1'b1, 32'h100, v);
    expect_xfer(1'b0, 32'h200, '0);
    access(1'b0, 32'h204, 32'h0, 1, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h200), 1) || st !== 1'b1) begin
      n_err++; $display("FAIL dirty_evict: got %h stall=%0b, required %h stall=1", rd, st, word(pat(32'h200), 1));
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL dirty_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clean_evict;
    logic [31:0] rd;
    logic st;
    expect_xfer(1'b0, 32'h100, '0);
    access(1'b0, 32'h104, 32'h0, 2, rd, st);
    n_vec++;
    if (rd !== 32'h1234_5678 || st !== 1'b1) begin
      n_err++; $display("FAIL clean_evict: got %h stall=%0b, required 12345678 stall=1", rd, st);
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL clean_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_ack_latency;
    int dl [3] = '{0, 1, 10};
    logic [31:0] a;
    logic [31:0] rd;
    logic st;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1010 * (i + 1);
      expect_xfer(1'b0, a, '0);
      access(1'b0, a + 32'h4, 32'h0, dl[i], rd, st);
      n_vec++;
      if (rd !== word(pat(a), 1) || st !== 1'b1) begin
        n_err++; $display("FAIL ack_latency_%0d: got %h stall=%0b, required %h stall=1", dl[i], rd, st, word(pat(a), 1));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL latency_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [127:0] v;
    logic [31:0] rd;
    logic st;
    expect_xfer(1'b0, 32'h4050, '0);
    access(1'b1, 32'h4054, 32'hCAFE_F00D, 1, rd, st);
    n_vec++;
    if (st !== 1'b1) begin n_err++; $display("FAIL store_miss_stall: got %0b, required 1", st); end
    access(1'b0, 32'h4054, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== 32'hCAFE_F00D || st !== 1'b0) begin
      n_err++; $display("FAIL store_miss_readback: got %h stall=%0b, required cafef00d stall=0", rd, st);
    end
    access(1'b0, 32'h1014, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h1010), 1) || st !== 1'b0) begin
      n_err++; $display("FAIL b2b_hit: got %h stall=%0b, required %h stall=0", rd, st, word(pat(32'h1010), 1));
    end
    v = pat(32'h4050);
    v[63:32] = 32'hCAFE_F00D;
    expect_xfer(1'b1, 32'h4050, v);
    expect_xfer(1'b0, 32'h5050, '0);
    access(1'b0, 32'h505C, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h5050), 3)) begin
      n_err++; $display("FAIL store_miss_evict: got %h, required %h", rd, word(pat(32'h5050), 3));
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stray_ack;
    logic [31:0] rd;
    logic st;
    @(negedge clk);
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    n_vec++;
    if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL stray_ack_req: got %0b, required 0", mem_req_o); end
    access(1'b0, 32'h1014, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h1010), 1) || st !== 1'b0) begin
      n_err++; $display("FAIL stray_ack_hit: got %h stall=%0b, required %h stall=0", rd, st, word(pat(32'h1010), 1));
    end
  endtask

  task automatic test_reset_in_fill;
    logic [31:0] rd;
    logic st;
    bit seen;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h6064;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      seen = mem_req_o;
    end
    n_vec++;
    if (!seen || mem_addr_o !== 32'h6060 || mem_we_o !== 1'b0) begin
      n_err++; $display("FAIL rst_fill_start: got req=%0b we=%0b addr=%h, required req=1 we=0 addr=00006060",
                        mem_req_o, mem_we_o, mem_addr_o);
    end
    repeat (3) @(negedge clk);
    rst_i = 1'b1; cpu_req_i = 1'b0; mem_rdata_i = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_fill_drop: got req=%0b stall=%0b, required 0/0", mem_req_o, cpu_stall_o);
    end
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    expect_xfer(1'b0, 32'h6060, '0);
    access(1'b0, 32'h6064, 32'h0, 1, rd, st);
    n_vec++;
    if (rd !== word(pat(32'h6060), 1) || st !== 1'b1) begin
      n_err++; $display("FAIL rst_fill_reload: got %h stall=%0b, required %h stall=1", rd, st, word(pat(32'h6060), 1));
    end
    expect_xfer(1'b0, 32'h100, '0);
    access(1'b0, 32'h104, 32'h0, 0, rd, st);
    n_vec++;
    if (rd !== 32'h1234_5678 || st !== 1'b1) begin
      n_err++; $display("FAIL rst_invalidates: got %h stall=%0b, required 12345678 stall=1", rd, st);
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_evict();
    test_ack_latency();
    test_back_to_back();
    test_stray_ack();
    test_reset_in_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per block (power of 2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port cpu_req_i  input  1  MEM-stage access valid (Memory_read or Memory_write).
REQ-006 SHALL have port cpu_we_i  input  1  1 means store, 0 means load.
REQ-007 SHALL have port cpu_addr_i  input  32  byte address (bits [1:0] ignored).
REQ-008 SHALL have port cpu_wdata_i  input  32  store data.
REQ-009 SHALL have port cpu_rdata_o  output  32  load data.
REQ-010 SHALL have port cpu_stall_o  output  1  freezes all pipeline registers and PC.
REQ-011 SHALL have port mem_req_o  output  1  block transfer request.
REQ-012 SHALL have port mem_we_o  output  1  1 means write-back, 0 means fill.
REQ-013 SHALL have port mem_addr_o  output  32  block-aligned address.
REQ-014 SHALL have port mem_wdata_o  output  32*WORDS  victim block.
REQ-015 SHALL have port mem_rdata_i  input  32*WORDS  fill block.
REQ-016 SHALL have port mem_ack_i  input  1  one-cycle pulse, transfer complete.

Function
REQ-017 SHALL decode the address as offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, and tag = remaining upper bits.
REQ-018 SHALL hold per line: valid, dirty, tag, data block.
REQ-019 SHALL detect a hit combinationally as cpu_req_i && valid[index] && tag match, with state IDLE.
REQ-020 SHALL, on a load hit, drive cpu_rdata_o with the selected word in the same cycle, with cpu_stall_o=0 (zero-cycle latency).
REQ-021 SHALL, on a store hit, write the word at the next edge, set dirty, and keep cpu_stall_o=0.
REQ-022 SHALL assert cpu_stall_o combinationally in the same cycle as a miss, and hold it until the cycle the access completes as a hit.
REQ-023 SHALL implement the FSM IDLE -> (miss, victim valid and dirty) WB -> FILL -> IDLE; IDLE -> (miss, victim clean or invalid) FILL -> IDLE.
REQ-024 SHALL, in WB, drive mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 0}, mem_wdata_o=victim block; on mem_ack_i, go to FILL.
REQ-025 SHALL, in FILL, drive mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, index, 0}; on mem_ack_i, write the block, set valid=1, tag=cpu tag, dirty=0, and go to IDLE.
REQ-026 SHALL, on the IDLE cycle after FILL, service the access as a hit; a store then sets dirty and cpu_stall_o drops in that cycle.
REQ-027 SHALL keep mem_req_o and mem_addr_o stable from assertion until mem_ack_i.
REQ-028 SHALL ignore mem_ack_i outside WB and FILL.
REQ-029 SHALL, while stalled, ignore changes on the cpu_* inputs, which the pipeline holds stable.
REQ-030 SHALL, when cpu_req_i=0, drive cpu_stall_o=0 and cpu_rdata_o=0, with no state change.

Reset
REQ-031 SHALL, when rst_i=1 at an edge, set the state to IDLE and clear all valid and dirty bits.
REQ-032 SHALL NOT clear tag or data arrays on reset.
REQ-033 SHALL, after reset, drive outputs cpu_stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0.
REQ-034 SHALL, when reset occurs mid-WB or mid-FILL, abandon the transfer, drop mem_req_o the next cycle, and write no array entry.

Structure
REQ-035 SHALL place the state enum (IDLE, WB, FILL) and the address field width constants in a shared package.
REQ-036 SHALL place the tag/valid/dirty/data storage in one sub-module, dcache_sram, with one read port and one write port.

Verification
REQ-037 SHALL verify a cold load: rst, then load 0x0000_0104 with a fill returning word1=0xDEAD_BEEF -> stall for FILL, one mem fill at 0x100, cpu_rdata_o=0xDEADBEEF.
REQ-038 SHALL verify a store hit: store 0x1234_5678 to 0x104 after the fill -> no stall; a later load of 0x104 returns 0x12345678.
REQ-039 SHALL verify a dirty eviction: after the store hit of REQ-038, load 0x0000_0204 (same index 0) -> WB at 0x100 with word1=0x12345678, then FILL at 0x200.
REQ-040 SHALL verify a clean eviction: a load conflicting with a clean line -> FILL only, no WB.
REQ-041 SHALL verify ack latency: mem_ack_i delayed 0, 1, and 10 cycles -> mem_req_o and mem_addr_o stay stable throughout.
REQ-042 SHALL verify reset in FILL: rst_i asserted before mem_ack_i -> IDLE, line invalid, and a reload misses again.
